core_sequencer: RTL

Multi-cycle instruction sequencer for the core. It steps each instruction through the fetch, decode, execute, optional memory and write-back units with one-cycle enable pulses, and waits for each unit's one-cycle done pulse before moving on. It owns the architectural PC and the retire counter, and it catches a unit that never answers. It sits between the top-level core wrapper and the stage units, and is the only block that drives their enables.

---
 rtl/core_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: walks each instruction through fetch, decode, execute, optional memory and write-back units.
// Latency: with zero-latency units, 4 cycles per non-memory instruction and 5 per load/store; start to fetch_enable is 1 cycle.
// Backpressure: stalls in each stage until that unit's done pulse; after TIMEOUT idle cycles it parks in ERROR until rst.

module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        fetch_enable,
  input  logic        fetch_done,
  input  logic [31:0] fetch_command,
  output logic        decode_enable,
  input  logic        decode_done,
  output logic        exec_enable,
  input  logic        exec_done,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        mem_enable,
  input  logic        mem_done,
  output logic        wb_enable,
  output logic [31:0] pc,
  output logic [31:0] command,
  output logic [31:0] retired,
  output logic        halted,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // Wait counter is 16 bits wide: TIMEOUT tops out at 65535 and the counter never passes it.
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [5:0]  OP_HALT   = 6'b111111;
  localparam logic [1:0]  CLS_MEM   = 2'b10;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_command;
  logic [31:0] r_retired;
  logic [15:0] r_wait;
  logic        r_jump;
  logic [31:0] r_jump_addr;
  logic        r_fetch_enable;
  logic        r_decode_enable;
  logic        r_exec_enable;
  logic        r_mem_enable;
  logic        r_wb_enable;
  logic        r_halted;
  logic        r_error;

  logic        w_done;
  logic        w_expired;
  logic        w_is_halt;
  logic        w_is_mem;
  logic [31:0] w_pc_next;

  // Pick the done pulse owned by the current wait state; done pulses from any other unit are stray and dropped here.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      S_FETCH:  w_done = fetch_done;
      S_DECODE: w_done = decode_done;
      S_EXEC:   w_done = exec_done;
      S_MEM:    w_done = mem_done;
      default:  w_done = 1'b0;
    endcase
  end

  // The wait budget is spent once the counter has reached TIMEOUT; a done arriving in that same cycle still wins.
  assign w_expired = (r_wait == TIMEOUT_W);

  // Instruction class decode on the latched word; halt is checked first because its opcode also sits in a non-memory class.
  assign w_is_halt = (r_command[31:26] == OP_HALT);
  assign w_is_mem  = (r_command[31:30] == CLS_MEM);

  // Next sequential or redirected pc, using the branch outcome captured at exec_done. Plain wrap-around add, no alignment check.
  assign w_pc_next = r_jump ? r_jump_addr : (r_pc + 32'd4);

  // Main sequencer: state, architectural pc, retire counter, wait counter and all registered stage enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_pc            <= RESET_PC;
      r_command       <= 32'd0;
      r_retired       <= 32'd0;
      r_wait          <= 16'd0;
      r_jump          <= 1'b0;
      r_jump_addr     <= 32'd0;
      r_fetch_enable  <= 1'b0;
      r_decode_enable <= 1'b0;
      r_exec_enable   <= 1'b0;
      r_mem_enable    <= 1'b0;
      r_wb_enable     <= 1'b0;
      r_halted        <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      // Enables are pulses: raised only on the transition into their state.
      r_fetch_enable  <= 1'b0;
      r_decode_enable <= 1'b0;
      r_exec_enable   <= 1'b0;
      r_mem_enable    <= 1'b0;
      r_wb_enable     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_FETCH;
            r_fetch_enable <= 1'b1;
            r_wait         <= 16'd0;
          end
        end

        S_FETCH, S_DECODE, S_EXEC, S_MEM: begin
          if (w_done) begin
            r_wait <= 16'd0;
            case (r_state)
              S_FETCH: begin
                r_command       <= fetch_command;
                r_state         <= S_DECODE;
                r_decode_enable <= 1'b1;
              end
              S_DECODE: begin
                r_state       <= S_EXEC;
                r_exec_enable <= 1'b1;
              end
              S_EXEC: begin
                r_jump      <= jump;
                r_jump_addr <= jump_addr;
                if (w_is_halt) begin
                  // A halt retires here: no write-back and the pc stays on the halt instruction.
                  r_state   <= S_HALT;
                  r_halted  <= 1'b1;
                  r_retired <= r_retired + 32'd1;
                end else if (w_is_mem) begin
                  r_state      <= S_MEM;
                  r_mem_enable <= 1'b1;
                end else begin
                  r_state     <= S_WB;
                  r_wb_enable <= 1'b1;
                end
              end
              default: begin
                // Only S_MEM reaches here.
                r_state     <= S_WB;
                r_wb_enable <= 1'b1;
              end
            endcase
          end else if (w_expired) begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
            r_wait  <= 16'd0;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end

        S_WB: begin
          // Single commit cycle: advance pc and retire count, then fetch the next instruction.
          r_pc           <= w_pc_next;
          r_retired      <= r_retired + 32'd1;
          r_state        <= S_FETCH;
          r_fetch_enable <= 1'b1;
          r_wait         <= 16'd0;
        end

        default: begin
          // HALT and ERROR are terminal; only rst leaves them and start is ignored.
          r_state <= r_state;
        end
      endcase
    end
  end

  assign fetch_enable  = r_fetch_enable;
  assign decode_enable = r_decode_enable;
  assign exec_enable   = r_exec_enable;
  assign mem_enable    = r_mem_enable;
  assign wb_enable     = r_wb_enable;
  assign pc            = r_pc;
  assign command       = r_command;
  assign retired       = r_retired;
  assign halted        = r_halted;
  assign error         = r_error;

  // At most one stage unit is ever enabled in a given cycle.
  a_enables_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({r_fetch_enable, r_decode_enable, r_exec_enable, r_mem_enable, r_wb_enable}));

  // The two terminal states are mutually exclusive.
  a_halt_error_excl: assert property (@(posedge clk) disable iff (rst) !(r_halted && r_error));

endmodule
